// File: rtl/crc32_pkg.sv
// Shared constants for the serial CRC-32 generator.
package crc32_pkg;

    localparam int unsigned CRC_W = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [CRC_W-1:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [CRC_W-1:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC32_XOROUT  = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC32_RESIDUE = 32'h00000000;

endpackage : crc32_pkg

// File: rtl/crc32_bit_step.sv
// One-bit MSB-first CRC update: shift left, fold in the polynomial when the
// outgoing bit differs from the incoming message bit.
module crc32_bit_step
    import crc32_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic             din,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] crc_next
);

    logic fb;

    always_comb begin
        fb       = crc_in[CRC_W-1] ^ din;
        crc_next = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    end

endmodule : crc32_bit_step

// File: rtl/crc32_generator.sv
// Serial CRC-32 generator with bit counter and zero-residue flag.
// Define CRC32_FINAL_XOR_EN to invert the CRC on crc_out.
module crc32_generator
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY,
    parameter logic [31:0] INIT = CRC32_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_in,
    input  logic        enable,
    output logic [31:0] crc_out,
    output logic [15:0] bit_cnt,
    output logic        residue_ok
);

`ifdef CRC32_FINAL_XOR_EN
    localparam logic [CRC_W-1:0] OUT_XOR = CRC32_XOROUT;
`else
    localparam logic [CRC_W-1:0] OUT_XOR = '0;
`endif

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_next;

    crc32_bit_step u_bit_step (
        .crc_in   (crc_q),
        .din      (data_in),
        .poly     (POLY),
        .crc_next (crc_next)
    );

    // crc_out is loaded alongside crc_q so it carries no extra latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q   <= INIT;
            crc_out <= INIT ^ OUT_XOR;
            bit_cnt <= '0;
        end else if (enable) begin
            crc_q   <= crc_next;
            crc_out <= crc_next ^ OUT_XOR;
            if (bit_cnt != '1) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    assign residue_ok = (crc_q == CRC32_RESIDUE);

endmodule : crc32_generator

// File: tb/tb_crc32_generator.sv
// Directed self-checking bench for crc32_generator (honours CRC32_FINAL_XOR_EN).
module tb_crc32_generator;

`ifdef CRC32_FINAL_XOR_EN
    localparam logic [31:0] XO = 32'hFFFFFFFF;
`else
    localparam logic [31:0] XO = 32'h00000000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_in = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] crc_out;
    logic [15:0] bit_cnt;
    logic        residue_ok;

    int checks = 0;
    int errors = 0;

    crc32_generator dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .enable     (enable),
        .crc_out    (crc_out),
        .bit_cnt    (bit_cnt),
        .residue_ok (residue_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_step(input logic [31:0] c, input logic d);
        logic fb;
        fb = c[31] ^ d;
        return {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic en);
        @(negedge clk);
        rst     = 1'b0;
        enable  = en;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        rst     = 1'b1;
        enable  = en;
        data_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) step(b[i], 1'b1);
    endtask

    task automatic feed_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) step(w[i], 1'b1);
    endtask

    initial begin
        logic [31:0] model;
        logic        b;

        // Reset state
        do_reset(1'b1);
        chk32("rst_crc", crc_out, 32'hFFFFFFFF ^ XO);
        chk16("rst_cnt", bit_cnt, 16'd0);
        chk1 ("rst_res", residue_ok, 1'b0);

        // 0xAB then idle: value must hold
        feed_byte(8'hAB);
        chk32("ab_crc", crc_out, 32'h946C22DB ^ XO);
        chk16("ab_cnt", bit_cnt, 16'd8);
        for (int k = 0; k < 5; k++) begin
            step(k[0], 1'b0);
            chk32("ab_hold_crc", crc_out, 32'h946C22DB ^ XO);
            chk16("ab_hold_cnt", bit_cnt, 16'd8);
        end

        // Single bits from reset
        do_reset(1'b0);
        step(1'b1, 1'b1);
        chk32("bit1_crc", crc_out, 32'hFFFFFFFE ^ XO);
        chk16("bit1_cnt", bit_cnt, 16'd1);
        do_reset(1'b0);
        step(1'b0, 1'b1);
        chk32("bit0_crc", crc_out, 32'hFB3EE249 ^ XO);

        // Mid-message reset with enable high, then re-feed
        do_reset(1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk16("mid_cnt", bit_cnt, 16'd4);
        do_reset(1'b1);
        chk32("mid_rst_crc", crc_out, 32'hFFFFFFFF ^ XO);
        chk16("mid_rst_cnt", bit_cnt, 16'd0);
        feed_byte(8'hAB);
        chk32("refeed_crc", crc_out, 32'h946C22DB ^ XO);

        // Message plus its CRC leaves a zero residue
        do_reset(1'b0);
        feed_byte(8'hAB);
        chk1("pre_res", residue_ok, 1'b0);
        feed_word(32'h946C22DB);
        chk32("res_crc", crc_out, 32'h00000000 ^ XO);
        chk1 ("res_ok", residue_ok, 1'b1);
        chk16("res_cnt", bit_cnt, 16'd40);

        // Counter saturation; CRC keeps moving afterwards
        do_reset(1'b0);
        model = 32'hFFFFFFFF;
        for (int n = 0; n < 65535; n++) begin
            b = n[0] ^ n[4] ^ n[9];
            step(b, 1'b1);
            model = model_step(model, b);
        end
        chk16("sat_cnt", bit_cnt, 16'hFFFF);
        chk32("sat_crc", crc_out, model ^ XO);
        for (int n = 0; n < 3; n++) begin
            b = n[0];
            step(b, 1'b1);
            model = model_step(model, b);
        end
        chk16("sat_hold_cnt", bit_cnt, 16'hFFFF);
        chk32("sat_post_crc", crc_out, model ^ XO);
        chk1 ("sat_res", residue_ok, model == 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_crc32_generator
